// File: rtl/input_switch_pkg.sv
// Shared types and helpers for the parametrised input switch.
// Imported by the top and the per-bit debounce slice.
package input_switch_pkg;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } state_e;

  // Fill bit of the default idle word (all ones).
  localparam logic IDLE_FILL = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/input_switch_n_debounce_bit.sv
// One pin bit: metastability synchroniser followed by a
// hold-for-N-cycles debouncer (bypassed when DEBOUNCE is 0).
module debounce_bit
  import input_switch_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 4,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic bit_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_pin;

  // Shift the raw pin through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  // Synchroniser flops start at the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_pin = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE == 0) begin : g_bypass

    assign bit_o = sync_pin;

  end else begin : g_deb

    localparam int CW  = clog2_min1(DEBOUNCE);
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] LIM = CW1'(DEBOUNCE);

    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW:0]   cnt_inc;

    // Count cycles of disagreement; accept on the DEBOUNCE-th.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      cnt_inc  = {1'b0, cnt_q} + 1'b1;
      if (sync_pin != stable_q) begin
        if (cnt_inc == LIM) begin
          stable_d = sync_pin;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
    end

    // Debounce state; reset discards any partial count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q <= RST_VAL;
        cnt_q    <= '0;
      end else begin
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign bit_o = stable_q;

  end

endmodule

// File: rtl/input_switch_n.sv
// Routes debounced pins to one of NUM_CPU ports with a
// blanking interval on every switchover.
module input_switch_n
  import input_switch_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_CPU     = 2,
  parameter int               SEL_W       = 1,
  parameter logic [WIDTH-1:0] IDLE_VAL    = {WIDTH{IDLE_FILL}},
  parameter int               SYNC_STAGES = 2,
  parameter int               DEBOUNCE    = 4,
  parameter int               BLANK       = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         ctr_io,
  input  logic [WIDTH-1:0]         input_pin,
  output logic [NUM_CPU*WIDTH-1:0] input_to_cpu,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     switching
);

  localparam int BW   = clog2_min1(BLANK);
  localparam int SW1  = SEL_W + 1;
  localparam logic [BW-1:0] BLANK_LD = BW'(BLANK - 1);
  localparam logic [SEL_W:0] NCPU    = SW1'(NUM_CPU);

  logic [WIDTH-1:0] deb_word;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE),
      .RST_VAL    (IDLE_VAL[i])
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .pin_i(input_pin[i]),
      .bit_o(deb_word[i])
    );
  end

  logic [SYNC_STAGES-1:0][SEL_W-1:0] sel_sync_q;
  logic [SYNC_STAGES-1:0][SEL_W-1:0] sel_sync_d;
  logic [SEL_W-1:0]                  sync_sel;
  logic                              sel_ok;

  state_e                     state_q;
  state_e                     state_d;
  logic [BW-1:0]              blank_q;
  logic [BW-1:0]              blank_d;
  logic [SEL_W-1:0]           active_sel_q;
  logic [SEL_W-1:0]           active_sel_d;
  logic [NUM_CPU*WIDTH-1:0]   out_q;
  logic [NUM_CPU*WIDTH-1:0]   out_d;
  logic                       switching_q;
  logic                       switching_d;

  // Shift the select request through its synchroniser.
  always_comb begin
    sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], ctr_io};
  end

  assign sync_sel = sel_sync_q[SYNC_STAGES-1];
  assign sel_ok   = ({1'b0, sync_sel} < NCPU);

  // Switchover sequencing: enter BLANK on a legal new request,
  // commit the select sampled on the last BLANK cycle.
  always_comb begin
    state_d      = state_q;
    blank_d      = blank_q;
    active_sel_d = active_sel_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (sel_ok && (sync_sel != active_sel_q)) begin
          state_d = ST_BLANK;
          blank_d = BLANK_LD;
        end
      end
      ST_BLANK: begin
        if (blank_q == '0) begin
          state_d = ST_ACTIVE;
          if (sel_ok) begin
            active_sel_d = sync_sel;
          end
        end else begin
          blank_d = blank_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  // Output word follows the next state so that the port view
  // and the state registers always change on the same edge.
  always_comb begin
    out_d       = {NUM_CPU{IDLE_VAL}};
    switching_d = (state_d == ST_BLANK);
    if (state_d == ST_ACTIVE) begin
      for (int k = 0; k < NUM_CPU; k++) begin
        if (active_sel_d == SEL_W'(k)) begin
          out_d[k*WIDTH +: WIDTH] = deb_word;
        end
      end
    end
  end

  // All control and output state; reset drops any switchover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync_q   <= '0;
      state_q      <= ST_ACTIVE;
      blank_q      <= '0;
      active_sel_q <= '0;
      out_q        <= {NUM_CPU{IDLE_VAL}};
      switching_q  <= 1'b0;
    end else begin
      sel_sync_q   <= sel_sync_d;
      state_q      <= state_d;
      blank_q      <= blank_d;
      active_sel_q <= active_sel_d;
      out_q        <= out_d;
      switching_q  <= switching_d;
    end
  end

  assign input_to_cpu = out_q;
  assign active_sel   = active_sel_q;
  assign switching    = switching_q;

endmodule

// File: tb/tb_input_switch_n.sv
// Bench for input_switch_n: a 2-port and a 3-port instance
// against a cycle model plus literal checkpoints.
module tb_input_switch_n;

  localparam int BLANK = 3;
  localparam int DEB   = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  input_pin;
  logic [0:0]  ctr2;
  logic [1:0]  ctr3;
  logic [15:0] out2;
  logic [23:0] out3;
  logic [0:0]  act2;
  logic [1:0]  act3;
  logic        sw2;
  logic        sw3;

  int n_checks = 0;
  int n_fail   = 0;

  input_switch_n u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctr_io      (ctr2),
    .input_pin   (input_pin),
    .input_to_cpu(out2),
    .active_sel  (act2),
    .switching   (sw2)
  );

  input_switch_n #(
    .NUM_CPU(3),
    .SEL_W  (2)
  ) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctr_io      (ctr3),
    .input_pin   (input_pin),
    .input_to_cpu(out3),
    .active_sel  (act3),
    .switching   (sw3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Model: pin seen two cycles late, each bit must disagree for
  // DEB straight samples to flip, switchover idles BLANK cycles.
  logic [7:0] pin_s1, pin_s2, stable;
  int         run [8];
  int         sel_a [2];
  int         sel_b [2];
  int         act [2];
  int         blank_left [2];
  logic [7:0] exp_out [2][3];
  bit         model_ok = 1'b0;

  task automatic model_reset();
    pin_s1 = 8'hFF;
    pin_s2 = 8'hFF;
    stable = 8'hFF;
    for (int b = 0; b < 8; b++) run[b] = 0;
    for (int d = 0; d < 2; d++) begin
      sel_a[d] = 0;
      sel_b[d] = 0;
      act[d] = 0;
      blank_left[d] = 0;
      for (int k = 0; k < 3; k++) exp_out[d][k] = 8'hFF;
    end
    model_ok = 1'b1;
  endtask

  task automatic model_step();
    int ncpu;
    for (int d = 0; d < 2; d++) begin
      ncpu = (d == 0) ? 2 : 3;
      if (blank_left[d] == 0) begin
        if (sel_b[d] < ncpu && sel_b[d] != act[d])
          blank_left[d] = BLANK;
      end else begin
        blank_left[d]--;
        if (blank_left[d] == 0 && sel_b[d] < ncpu)
          act[d] = sel_b[d];
      end
      for (int k = 0; k < 3; k++)
        exp_out[d][k] = (blank_left[d] == 0 && k == act[d]) ?
                        stable : 8'hFF;
    end
    for (int b = 0; b < 8; b++) begin
      if (pin_s2[b] == stable[b]) begin
        run[b] = 0;
      end else begin
        run[b]++;
        if (run[b] == DEB) begin
          stable[b] = pin_s2[b];
          run[b] = 0;
        end
      end
    end
    pin_s2 = pin_s1;
    pin_s1 = input_pin;
    sel_b[0] = sel_a[0];
    sel_b[1] = sel_a[1];
    sel_a[0] = int'(ctr2);
    sel_a[1] = int'(ctr3);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("m2_slice%0d", k), 32'(out2[k*8 +: 8]),
            32'(exp_out[0][k]));
      chk("m2_act", 32'(act2), 32'(act[0]));
      chk("m2_sw", 32'(sw2), 32'(blank_left[0] != 0));
      for (int k = 0; k < 3; k++)
        chk($sformatf("m3_slice%0d", k), 32'(out3[k*8 +: 8]),
            32'(exp_out[1][k]));
      chk("m3_act", 32'(act3), 32'(act[1]));
      chk("m3_sw", 32'(sw3), 32'(blank_left[1] != 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    input_pin = 8'h00;
    ctr2 = 1'b0;
    ctr3 = 2'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    tick(3);
    chk("rst_out2", 32'(out2), 32'h0000FFFF);
    chk("rst_out3", 32'(out3), 32'h00FFFFFF);
    chk("rst_act2", 32'(act2), 32'd0);
    chk("rst_sw2", 32'(sw2), 32'd0);
    rst_n = 1'b1;
    tick(6);
    chk("rst_hold", 32'(out2[7:0]), 32'hFF);
    tick(1);
    chk("rst_prop", 32'(out2[7:0]), 32'h00);

    // Latency
    input_pin = 8'hFF;
    tick(10);
    input_pin = 8'h5A;
    tick(6);
    chk("lat_6", 32'(out2[7:0]), 32'hFF);
    tick(1);
    chk("lat_7", 32'(out2[7:0]), 32'h5A);
    chk("lat_s1", 32'(out2[15:8]), 32'hFF);

    // Glitch filter
    input_pin = 8'hFF;
    tick(10);
    input_pin = 8'hFE;
    tick(3);
    input_pin = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch3", 32'(out2[7:0]), 32'hFF);
    end
    input_pin = 8'hFE;
    tick(4);
    input_pin = 8'hFF;
    tick(3);
    chk("pulse4_on", 32'(out2[7:0]), 32'hFE);
    tick(3);
    chk("pulse4_hold", 32'(out2[7:0]), 32'hFE);
    tick(1);
    chk("pulse4_off", 32'(out2[7:0]), 32'hFF);

    // Switchover 0 -> 1
    input_pin = 8'h3C;
    tick(10);
    ctr2 = 1'b1;
    tick(2);
    chk("sw_old", 32'(out2), 32'h0000FF3C);
    chk("sw_pre", 32'(sw2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("sw_idle", 32'(out2), 32'h0000FFFF);
      chk("sw_flag", 32'(sw2), 32'd1);
    end
    tick(1);
    chk("sw_new", 32'(out2), 32'h00003CFF);
    chk("sw_act", 32'(act2), 32'd1);
    chk("sw_done", 32'(sw2), 32'd0);

    // Out-of-range select ignored
    ctr3 = 2'd3;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("oor_act", 32'(act3), 32'd0);
      chk("oor_sw", 32'(sw3), 32'd0);
    end

    // Mid-BLANK select change: last BLANK sample wins
    ctr3 = 2'd2;
    tick(2);
    chk("mb_pre", 32'(sw3), 32'd0);
    tick(1);
    chk("mb_b1", 32'(sw3), 32'd1);
    chk("mb_idle", 32'(out3), 32'h00FFFFFF);
    ctr3 = 2'd1;
    tick(1);
    chk("mb_b2", 32'(sw3), 32'd1);
    tick(1);
    chk("mb_b3", 32'(sw3), 32'd1);
    tick(1);
    chk("mb_act", 32'(act3), 32'd1);
    chk("mb_sw", 32'(sw3), 32'd0);
    chk("mb_out", 32'(out3), 32'h00FF3CFF);

    // Reset mid-BLANK
    ctr2 = 1'b0;
    tick(4);
    chk("rb_in", 32'(sw2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_sw", 32'(sw2), 32'd0);
    chk("rb_out", 32'(out2), 32'h0000FFFF);
    chk("rb_act3", 32'(act3), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rb_act", 32'(act2), 32'd0);
    chk("rb_sw2", 32'(sw2), 32'd0);
    tick(4);
    chk("rb_data", 32'(out2), 32'h0000FF3C);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_switch_n.md
# input_switch_n

Parametrised successor to the two-CPU input switch. It routes one bus of external input pins to exactly one of NUM_CPU processor input ports, selected by a control line, and drives every unselected port to a constant idle value. It adds input synchronisation, per-bit debouncing, and a glitch-free switchover with a blanking interval. It sits between the board input pins and the per-CPU GPIO input registers in the redundant-core switching fabric.

## Interface
- WIDTH, 8: pin bus width in bits.
- NUM_CPU, 2: number of CPU ports; legal range 2..16.
- SEL_W, 1: width of the select input; must satisfy 2**SEL_W >= NUM_CPU.
- IDLE_VAL, all ones (WIDTH bits): value driven on unselected ports and used as the reset value.
- SYNC_STAGES, 2: synchroniser depth for both the pins and the select line; minimum 2.
- DEBOUNCE, 4: consecutive cycles a synchronised bit must hold a new value before it is accepted; 0 bypasses debouncing.
- BLANK, 3: number of cycles during which all ports read IDLE_VAL at a switchover; minimum 1.

Ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: reset. Asynchronous assert, active-low.
- ctr_io, input, SEL_W: requested CPU index. Asynchronous to clk.
- input_pin, input, WIDTH: external pins. Asynchronous to clk.
- input_to_cpu, output, NUM_CPU*WIDTH: slice k is bits [k*WIDTH +: WIDTH] and feeds CPU k. Registered.
- active_sel, output, SEL_W: index of the currently connected CPU. Registered.
- switching, output, 1: high while in BLANK. Registered.

## Operation
- **Pin synchroniser:** SYNC_STAGES flops per bit, reset to IDLE_VAL. Output is sync_pin.
- **Select synchroniser:** SYNC_STAGES flops, reset to 0. Output is sync_sel.
- **Debouncer (one per bit):**
  - Holds a stable value (reset to the IDLE_VAL bit) and a counter (reset to 0).
  - If sync_pin equals stable, the counter clears.
  - Otherwise the counter increments. When the increment would reach DEBOUNCE, stable takes sync_pin and the counter clears.
  - Any return to the old value before then restarts the count.
- **FSM, two states:**
  - ACTIVE:
    - Slice active_sel gets the debounced word.
    - All other slices get IDLE_VAL.
    - If sync_sel != active_sel and sync_sel < NUM_CPU, go to BLANK and load the blank counter with BLANK-1.
    - If sync_sel >= NUM_CPU, the request is ignored; stay in ACTIVE with no change.
  - BLANK:
    - All slices get IDLE_VAL and switching is 1.
    - The counter decrements each cycle.
    - When it reads 0, load active_sel with sync_sel if sync_sel < NUM_CPU; otherwise keep the old value. Then go to ACTIVE.
    - Select changes during BLANK do not restart the interval; only the value sampled on the last BLANK cycle counts.
    - If that value equals the old active_sel, the return to ACTIVE is still required.
- **Reset:** asynchronous.
  - State ACTIVE, active_sel = 0, switching = 0.
  - All input_to_cpu slices = IDLE_VAL, all debouncers = IDLE_VAL.
  - Reset asserted mid-BLANK or mid-debounce discards all progress.

## Timing
- Pin to port latency for a clean, held edge: SYNC_STAGES + DEBOUNCE + 1 cycles. This is 7 with defaults, and SYNC_STAGES + 1 with DEBOUNCE = 0.
- A pulse on sync_pin shorter than DEBOUNCE cycles never reaches any port.
- Select change to first IDLE cycle on the old port: SYNC_STAGES + 1 cycles.
- The old port reads IDLE_VAL for exactly BLANK cycles.
- The new port shows the debounced word on the cycle after the last BLANK cycle.
- At no cycle are two ports non-idle at once.
- Debouncing continues during BLANK, so the new port shows current pin state with no extra latency.
- A pin change and a select change in the same cycle must not produce a mixed output: the new value appears only on the new port.

## Structure
- Shared package input_switch_pkg holds:
  - the state enum (ST_ACTIVE, ST_BLANK);
  - a clog2 helper for the debounce and blank counter widths;
  - the default IDLE_VAL constant.
- Sub-module debounce_bit: one synchroniser chain plus one debouncer for one bit, parameterised by SYNC_STAGES, DEBOUNCE and reset value. Instantiated WIDTH times in a generate loop.
- The select synchroniser, FSM and output mux/register stay in the top module.

## Test plan
1. **Reset.** Assert rst_n low with input_pin = 8'h00. Require all slices = 8'hFF, active_sel = 0 and switching = 0, both during reset and until the pin change propagates.
2. **Latency.** Defaults, ctr_io = 0, input_pin 8'hFF→8'h5A held. Require slice 0 = 8'h5A exactly 7 cycles later and slice 1 = 8'hFF throughout.
3. **Glitch filter.** Drive a 3-cycle pulse on bit 0 (8'hFF→8'hFE→8'hFF). Require slice 0 to stay 8'hFF. A 4-cycle pulse must appear.
4. **Switchover.** With input_pin = 8'h3C stable, change ctr_io 0→1. Require:
   - slice 0 = 8'h3C until 3 cycles after the change;
   - then all slices 8'hFF and switching = 1 for 3 cycles;
   - then slice 1 = 8'h3C and active_sel = 1.
5. **Out-of-range and mid-BLANK select.** NUM_CPU = 3, SEL_W = 2:
   - ctr_io = 3: no change ever.
   - ctr_io 0→2→1 with the 1 present at the last BLANK cycle: require active_sel = 1 and exactly BLANK idle cycles.
6. **Reset mid-BLANK.** Assert rst_n during BLANK. Require immediate all-idle outputs, switching = 0, and active_sel = 0 after release.
